// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory fetch port between the fetch stage (master) and memory (slave).
interface if_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    modport master (output imem_req, imem_addr, input imem_rdy, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_rdy, imem_data);
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a one-entry stall buffer feeding the IF/ID register.
// Optional IF_HALT_DETECT_EN: stop fetching once an opcode-5'b00000 instruction enters IF/ID.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    if_stage_if.master  imem,
    input  logic [15:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] pc_inc,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_inc,
    output logic        if_id_valid,
    output logic        halted
);
    localparam logic [1:0] FETCH = 2'd0, HOLD = 2'd1, HALT = 2'd2;
    logic [1:0]  state;
    logic [15:0] pc, hold_instr, hold_pc_inc;
    logic        halt_f, halt_h;
    assign pc_inc         = pc + 16'd2;
    assign imem.imem_req  = state == FETCH;
    assign imem.imem_addr = pc;
`ifdef IF_HALT_DETECT_EN
    assign halt_f = imem.imem_data[15:11] == 5'd0;
    assign halt_h = hold_instr[15:11] == 5'd0;
    assign halted = state == HALT;
`else
    assign halt_f = 1'b0;
    assign halt_h = 1'b0;
    assign halted = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            hold_instr   <= 16'h0000;
            hold_pc_inc  <= 16'h0000;
            if_id_instr  <= 16'h0000;
            if_id_pc_inc <= 16'h0000;
            if_id_valid  <= 1'b0;
        end else if (state != HALT) begin
            if (flush) begin
                pc          <= next_pc;
                if_id_valid <= 1'b0;
                hold_instr  <= 16'h0000;
                hold_pc_inc <= 16'h0000;
                state       <= FETCH;
            end else if (state == FETCH && imem.imem_rdy) begin
                if (stall) begin
                    hold_instr  <= imem.imem_data;
                    hold_pc_inc <= pc_inc;
                    state       <= HOLD;
                end else begin
                    if_id_instr  <= imem.imem_data;
                    if_id_pc_inc <= pc_inc;
                    if_id_valid  <= 1'b1;
                    pc           <= next_pc;
                    state        <= halt_f ? HALT : FETCH;
                end
            end else if (state == FETCH) begin
                // memory not ready: drop a bubble only if downstream is consuming
                if (!stall) if_id_valid <= 1'b0;
            end else if (!stall) begin
                if_id_instr  <= hold_instr;
                if_id_pc_inc <= hold_pc_inc;
                if_id_valid  <= 1'b1;
                pc           <= next_pc;
                state        <= halt_h ? HALT : FETCH;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized scoreboard bench for if_stage; a one-slot pending model predicts IF/ID deliveries.
module tb_if_stage;
    localparam logic [15:0] RESET_PC = 16'h0000;
    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [15:0] next_pc = 16'h0000;
    logic [15:0] pc_inc, if_id_instr, if_id_pc_inc;
    logic        if_id_valid, halted;
    if_stage_if imem();
    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .imem(imem), .next_pc(next_pc), .stall(stall), .flush(flush),
        .pc_inc(pc_inc), .if_id_instr(if_id_instr), .if_id_pc_inc(if_id_pc_inc),
        .if_id_valid(if_id_valid), .halted(halted)
    );
    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b1;
    logic [15:0] m_pc = RESET_PC;
    bit          m_pend = 1'b0;
    logic [31:0] m_buf = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] rnd_instr();
        logic [15:0] d = 16'($urandom);
        if (d[15:11] == 5'd0) d[15] = 1'b1;
        return d;
    endfunction

    // Fetched words wait in a single pending slot until downstream stops stalling.
    task automatic step(input logic rdy, input logic st, input logic fl, input logic [15:0] data, input logic [15:0] npc);
        @(negedge clk);
        chk("imem_req", {31'd0, imem.imem_req}, {31'd0, !m_pend});
        chk("imem_addr", {16'd0, imem.imem_addr}, {16'd0, m_pc});
        chk("pc_inc", {16'd0, pc_inc}, {16'd0, 16'(m_pc + 16'd2)});
        chk("halted", {31'd0, halted}, 32'd0);
        imem.imem_rdy = rdy; imem.imem_data = data; stall = st; flush = fl; next_pc = npc;
        @(posedge clk);
        if (fl) begin
            m_pc = npc; m_pend = 1'b0;
        end else if (m_pend) begin
            if (!st) begin exp_q.push_back(m_buf); m_pc = npc; m_pend = 1'b0; end
        end else if (rdy) begin
            if (st) begin m_buf = {data, 16'(m_pc + 16'd2)}; m_pend = 1'b1; end
            else begin exp_q.push_back({data, 16'(m_pc + 16'd2)}); m_pc = npc; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem.imem_rdy = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
        imem.imem_data = rnd_instr(); next_pc = 16'($urandom);
        repeat (2) @(posedge clk);
        m_pc = RESET_PC; m_pend = 1'b0; exp_q.delete();
        @(negedge clk);
        chk("rst_instr", {16'd0, if_id_instr}, 32'd0);
        chk("rst_pc_inc", {16'd0, if_id_pc_inc}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_addr", {16'd0, imem.imem_addr}, {16'd0, RESET_PC});
        chk("rst_req", {31'd0, imem.imem_req}, 32'd1);
        rst_n = 1'b1; flush = 1'b0; stall = 1'b0; imem.imem_rdy = 1'b0;
    endtask

    // Decode-side monitor: an IF/ID entry leaves when downstream accepts it or a flush kills it.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && mon_en) begin
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, exp_q.size() != 0});
            if (if_id_valid && exp_q.size() != 0) begin
                chk("if_id_entry", {if_id_instr, if_id_pc_inc}, exp_q[0]);
                if (!stall || flush) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] ra;
        imem.imem_rdy = 1'b0; imem.imem_data = 16'h0;
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, rnd_instr(), 16'(m_pc + 16'd2));
        step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0010);
        repeat (3) step(1'b0, 1'b0, 1'b0, rnd_instr(), 16'(m_pc + 16'd2));
        step(1'b1, 1'b0, 1'b0, 16'h4A21, 16'(m_pc + 16'd2));
        #2;
        chk("wait_instr", {16'd0, if_id_instr}, 32'h4A21);
        chk("wait_pc_inc", {16'd0, if_id_pc_inc}, 32'h0012);
        step(1'b1, 1'b1, 1'b0, 16'h9ABC, 16'(m_pc + 16'd2));
        #2;
        chk("hold_req", {31'd0, imem.imem_req}, 32'd0);
        chk("hold_iid", {16'd0, if_id_instr}, 32'h4A21);
        step(1'b1, 1'b1, 1'b0, rnd_instr(), 16'(m_pc + 16'd2));
        step(1'b0, 1'b0, 1'b0, rnd_instr(), 16'(m_pc + 16'd2));
        #2;
        chk("hold_release", {16'd0, if_id_instr}, 32'h9ABC);
        chk("hold_back_req", {31'd0, imem.imem_req}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 16'h5555, 16'(m_pc + 16'd2));
        step(1'b0, 1'b1, 1'b1, rnd_instr(), 16'h0100);
        #2;
        chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
        chk("flush_addr", {16'd0, imem.imem_addr}, 32'h0100);
        step(1'b1, 1'b0, 1'b0, rnd_instr(), 16'(m_pc + 16'd2));
        step(1'b0, 1'b0, 1'b1, 16'h0, 16'hFFFE);
        #2;
        chk("wrap_pc_inc", {16'd0, pc_inc}, 32'h0000);
        step(1'b1, 1'b0, 1'b0, rnd_instr(), 16'h0000);
        #2;
        chk("wrap_if_id_pc_inc", {16'd0, if_id_pc_inc}, 32'h0000);
        step(1'b1, 1'b1, 1'b0, rnd_instr(), 16'(m_pc + 16'd2));
        do_reset();
        repeat (3000) begin
            case ($urandom_range(0, 9))
                7: ra = 16'hFFFE;
                8, 9: begin ra = 16'($urandom); ra[0] = 1'b0; end
                default: ra = 16'(m_pc + 16'd2);
            endcase
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, rnd_instr(), ra);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0, m_pc);
        @(negedge clk);
        #2;
        chk("drain", exp_q.size(), 32'd0);
        do_reset();
        mon_en = 1'b0;
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'(m_pc + 16'd2));
        repeat (4) begin
            @(negedge clk);
            imem.imem_rdy = 1'b1; stall = 1'b0; imem.imem_data = rnd_instr(); next_pc = 16'($urandom);
`ifdef IF_HALT_DETECT_EN
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_req", {31'd0, imem.imem_req}, 32'd0);
            chk("halt_iid", {16'd0, if_id_instr}, 32'h0000);
            chk("halt_valid", {31'd0, if_id_valid}, 32'd1);
`else
            chk("nohalt_flag", {31'd0, halted}, 32'd0);
            chk("nohalt_req", {31'd0, imem.imem_req}, 32'd1);
`endif
        end
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 next_pc  input  16  next fetch address from the next-PC computation stage.
REQ-005 stall  input  1  downstream cannot accept a new IF/ID entry this cycle.
REQ-006 flush  input  1  redirect: load next_pc, kill IF/ID contents.
REQ-007 imem_rdy  input  1  instruction memory returns valid imem_data this cycle.
REQ-008 imem_data  input  16  instruction word from instruction memory.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  16  fetch address, equal to current PC.
REQ-011 pc_inc  output  16  current PC + 2, fed to the next-PC computation stage.
REQ-012 if_id_instr  output  16  registered instruction to decode.
REQ-013 if_id_pc_inc  output  16  registered PC + 2 of if_id_instr.
REQ-014 if_id_valid  output  1  IF/ID entry holds a live instruction.
REQ-015 halted  output  1  fetch stopped on HALT opcode.

Function
REQ-016 pc_inc SHALL be combinational pc + 2, modulo 2^16 (16'hFFFE -> 16'h0000); imem_addr SHALL equal pc.
REQ-017 FSM states SHALL be FETCH, HOLD, HALT; imem_req SHALL be 1 only in FETCH.
REQ-018 FETCH, imem_rdy=1, stall=0: IF/ID <= {imem_data, pc_inc, valid=1}, pc <= next_pc, stay FETCH.
REQ-019 FETCH, imem_rdy=1, stall=1: hold buffer <= {imem_data, pc_inc}, IF/ID and pc unchanged, go HOLD.
REQ-020 FETCH, imem_rdy=0, stall=0: if_id_valid <= 0 (bubble), pc unchanged, imem_addr stable, stay FETCH.
REQ-021 FETCH, imem_rdy=0, stall=1: all state unchanged.
REQ-022 HOLD, stall=1: all state unchanged, no new request.
REQ-023 HOLD, stall=0: IF/ID <= hold buffer with valid=1, pc <= next_pc, go FETCH.
REQ-024 flush=1 in FETCH or HOLD SHALL take priority over stall and imem_rdy: pc <= next_pc, if_id_valid <= 0, hold buffer discarded, go FETCH.
REQ-025 Latency: instruction accepted at edge N SHALL appear on if_id_* after edge N; pc for the following fetch SHALL be valid after the same edge.
REQ-026 With stall held, if_id_* SHALL remain bit-identical every cycle.

Reset
REQ-027 rst_n=0 at a rising edge SHALL set pc=RESET_PC, state=FETCH, if_id_instr=16'h0000, if_id_pc_inc=16'h0000, if_id_valid=0, halted=0, hold buffer cleared, overriding all other inputs in any state.
REQ-028 Reset mid-WAIT or mid-HOLD SHALL discard the pending instruction; first post-reset request SHALL use address RESET_PC.

Configuration
REQ-029 Macro IF_HALT_DETECT_EN: when defined, an instruction with bits [15:11]=5'b00000 written into IF/ID (REQ-018/REQ-023) SHALL move the FSM to HALT in the same edge; HALT SHALL keep imem_req=0, pc frozen, halted=1, IF/ID held; only reset leaves HALT; flush in the same cycle as the HALT write SHALL win (no HALT entry).
REQ-030 Without IF_HALT_DETECT_EN: opcode 5'b00000 SHALL be treated as any other instruction, state HALT SHALL be unreachable, halted SHALL be constant 0.

Verification
REQ-031 Reset with RESET_PC=16'h0000, imem_rdy=1, stall=0, next_pc=pc_inc: imem_addr sequence 0000,0002,0004; if_id_pc_inc 0002,0004,0006, if_id_valid=1 from second cycle.
REQ-032 imem_rdy low 3 cycles at addr 16'h0010, stall=0: imem_addr stays 0010, three bubbles (if_id_valid=0), then instruction 16'h4A21 with if_id_pc_inc=16'h0012.
REQ-033 imem_rdy=1 with stall=1 for 2 cycles, imem_data=16'h9ABC: HOLD entered, imem_req=0, IF/ID unchanged; stall drop -> if_id_instr=16'h9ABC next edge, back to FETCH.
REQ-034 flush=1 with stall=1 in HOLD, next_pc=16'h0100: if_id_valid=0, buffered instruction never appears, next imem_addr=16'h0100.
REQ-035 PC=16'hFFFE, accept: pc_inc=16'h0000, if_id_pc_inc=16'h0000.
REQ-036 IF_HALT_DETECT_EN defined, fetch 16'h0000: halted=1 after the write edge, imem_req=0 indefinitely until rst_n=0; same stimulus with macro undefined: fetch continues, halted=0.
